spi_tx_fifo: RTL and testbench

- Command FIFO that buffers 24-bit SPI words from the host/config logic and feeds the SPI transmitter stage directly downstream through its BUS_DATA / bus_valid / spi_ready handshake.
- Lets producers queue bursts of register writes without waiting for each ~12 us SPI frame (24 bits at 50/24 MHz, plus CS gap) to finish.
- First-word-fall-through (FWFT): the head word is presented as soon as the FIFO is non-empty.

---
 rtl/spi_tx_fifo.sv | 111 +++++++++++
 tb/tb_spi_tx_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: first-word-fall-through command FIFO that queues 24-bit SPI
// words from the host and hands them to the SPI transmitter through a
// BUS_DATA / bus_valid / spi_ready handshake.
module spi_tx_fifo #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AW        = 4,
   parameter int unsigned AFULL_LVL = 14
) (
   input  logic          clk,
   input  logic          RSTn,
   input  logic [23:0]   wr_data,
   input  logic          wr_en,
   output logic          full,
   output logic          afull,
   output logic          ovf,
   input  logic          ovf_clr,
   output logic [AW:0]   level,
   output logic [23:0]   BUS_DATA,
   output logic          bus_valid,
   input  logic          spi_ready
);

   localparam int unsigned DW = 24;
   localparam int unsigned LW = AW + 1;

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;
   logic          ovf_q,    ovf_d;

   logic          push;
   logic          pop;

   // Status flags come straight from the registered level, so spi_ready
   // reaches the outputs only through the state registers.
   always_comb begin
      full      = (level_q == LW'(DEPTH));
      afull     = (level_q >= LW'(AFULL_LVL));
      bus_valid = (level_q != '0);
      level     = level_q;
      ovf       = ovf_q;
   end

   // Head word is presented whenever the FIFO holds data, zero otherwise.
   always_comb begin
      BUS_DATA = '0;
      if (bus_valid) begin
         BUS_DATA = mem[rd_ptr_q];
      end
   end

   // Handshake qualification; a write while full is dropped even if a pop
   // frees a slot on the same edge.
   always_comb begin
      push = wr_en && !full;
      pop  = bus_valid && spi_ready;
   end

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end

      // Setting has priority over a coincident clear.
      if (wr_en && full) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // Control state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_spi_tx_fifo.sv
// tb_spi_tx_fifo: directed plus randomized stimulus for spi_tx_fifo, checked
// against a queue-based reference model and a pop-side scoreboard.
module tb_spi_tx_fifo;

   localparam int unsigned DEPTH     = 16;
   localparam int unsigned AW        = 4;
   localparam int unsigned AFULL_LVL = 14;

   logic          clk;
   logic          rst_n;
   logic [23:0]   wr_data;
   logic          wr_en;
   logic          full;
   logic          afull;
   logic          ovf;
   logic          ovf_clr;
   logic [AW:0]   level;
   logic [23:0]   bus_data;
   logic          bus_valid;
   logic          spi_ready;

   int unsigned n_checks;
   int unsigned n_errors;

   // Reference model: stored words in order, plus the sticky overflow bit.
   logic [23:0] sb[$];
   logic        ovf_m;

   spi_tx_fifo #(
      .DEPTH     (DEPTH),
      .AW        (AW),
      .AFULL_LVL (AFULL_LVL)
   ) dut (
      .clk       (clk),
      .RSTn      (rst_n),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .full      (full),
      .afull     (afull),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .level     (level),
      .BUS_DATA  (bus_data),
      .bus_valid (bus_valid),
      .spi_ready (spi_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor and model, evaluated mid-cycle while inputs and outputs are stable.
   always @(negedge clk) begin
      logic m_push;
      logic m_pop;
      int   sz;
      if (!rst_n) begin
         sb.delete();
         ovf_m = 1'b0;
      end
      sz = sb.size();
      chk("level", 32'(level), 32'(sz));
      chk("bus_valid", 32'(bus_valid), 32'(sz != 0));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("afull", 32'(afull), 32'(sz >= AFULL_LVL));
      chk("ovf", 32'(ovf), 32'(ovf_m));
      if (sz == 0) chk("bus_data_idle", 32'(bus_data), 32'h0);
      if (rst_n) begin
         m_pop  = (sz != 0) && spi_ready;
         m_push = wr_en && (sz != DEPTH);
         // Scoreboard side: the transmitter latches the head word on accept.
         if (m_pop) begin
            chk("pop_data", 32'(bus_data), 32'(sb[0]));
            void'(sb.pop_front());
         end
         // Stimulus side: an accepted write becomes an expected output word.
         if (m_push) sb.push_back(wr_data);
         if (wr_en && sz == DEPTH) ovf_m = 1'b1;
         else if (ovf_clr)        ovf_m = 1'b0;
      end
   end

   task automatic step(input logic we, input logic [23:0] d, input logic rdy, input logic clr);
      @(posedge clk);
      #1;
      wr_en     = we;
      wr_data   = d;
      spi_ready = rdy;
      ovf_clr   = clr;
   endtask

   task automatic idle();
      step(1'b0, 24'h0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 24'h0, 1'b1, 1'b0);
      idle();
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      ovf_m     = 1'b0;
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;
      spi_ready = 1'b0;
      ovf_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_bus_data", 32'(bus_data), 32'h0);
      rst_n = 1'b1;

      // Three pushes with the transmitter busy.
      step(1'b1, 24'hA55A01, 1'b0, 1'b0);
      step(1'b1, 24'h123456, 1'b0, 1'b0);
      chk("fwft_level1", 32'(level), 32'd1);
      chk("fwft_head", 32'(bus_data), 32'hA55A01);
      step(1'b1, 24'hFFFF00, 1'b0, 1'b0);
      chk("level2", 32'(level), 32'd2);
      idle();
      chk("level3", 32'(level), 32'd3);
      chk("head_still", 32'(bus_data), 32'hA55A01);

      // One accept per simulated SPI frame.
      for (int f = 0; f < 3; f++) begin
         repeat (29) idle();
         step(1'b0, 24'h0, 1'b1, 1'b0);
      end
      idle();
      chk("drained_valid", 32'(bus_valid), 32'h0);
      chk("drained_data", 32'(bus_data), 32'h0);

      // Fill to full, then one overflowing write.
      for (int i = 1; i <= 16; i++) step(1'b1, 24'(i), 1'b0, 1'b0);
      step(1'b1, 24'hDEAD00, 1'b0, 1'b0);
      idle();
      chk("full_level", 32'(level), 32'd16);
      chk("full_flag", 32'(full), 32'h1);
      chk("ovf_set", 32'(ovf), 32'h1);
      chk("full_head", 32'(bus_data), 32'h000001);
      drain();

      // Write dropped at full even with a coincident pop; ovf clear priority.
      step(1'b0, 24'h0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0);
      step(1'b1, 24'hBAD000, 1'b1, 1'b0);
      idle();
      chk("drop_pop_level", 32'(level), 32'd15);
      chk("drop_pop_ovf", 32'(ovf), 32'h1);
      step(1'b0, 24'h0, 1'b0, 1'b1);
      idle();
      chk("ovf_clr", 32'(ovf), 32'h0);
      step(1'b1, 24'($urandom), 1'b0, 1'b0);
      step(1'b1, 24'hBAD001, 1'b0, 1'b1);
      idle();
      chk("ovf_set_wins", 32'(ovf), 32'h1);
      chk("ovf_set_level", 32'(level), 32'd16);
      drain();

      // Streaming at level 5: simultaneous push/pop, pointers wrap repeatedly.
      for (int i = 0; i < 5; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 24'($urandom), 1'b1, 1'b0);
      idle();
      chk("stream_level", 32'(level), 32'd5);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) < 6), 24'($urandom),
              ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
      end
      drain();

      // Asynchronous reset mid-cycle with seven words queued.
      for (int i = 0; i < 7; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0);
      idle();
      chk("pre_rst_level", 32'(level), 32'd7);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_level", 32'(level), 32'h0);
      chk("arst_valid", 32'(bus_valid), 32'h0);
      chk("arst_data", 32'(bus_data), 32'h0);
      chk("arst_full", 32'(full), 32'h0);
      chk("arst_ovf", 32'(ovf), 32'h0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      step(1'b1, 24'h0ABCDE, 1'b0, 1'b0);
      idle();
      chk("post_rst_head", 32'(bus_data), 32'h0ABCDE);
      chk("post_rst_level", 32'(level), 32'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
